bambu_mem_port_arbiter: RTL and testbench
=========================================

# bambu_mem_port_arbiter

Two-channel memory controller that serves the dual byte-lane master port of a Bambu-generated top (per-channel oe/we/addr/wdata/size, answered by DataRdy/Rdata) from a single-port on-chip byte memory. It arbitrates round-robin between the two lanes and applies programmable read and write latencies. It returns per-lane read data and ready pulses in the format the top expects. It sits between the accelerator's master port and the local scratch memory, in place of the behavioural memory model used in simulation.

## Interface
- ADDR_W, 7, byte address width per lane; memory depth is 2^ADDR_W bytes.
- DATA_W, 8, lane data width. Fixed at 8 in this release.
- READ_DELAY, 2, cycles from grant to read `data_rdy`. Must be >= 1.
- WRITE_DELAY, 1, cycles from grant to write `data_rdy`. Must be >= 1.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_oe  in  2  per-lane read request. The master holds it until `data_rdy`.
- req_we  in  2  per-lane write request. The master holds it until `data_rdy`.
- req_addr  in  2*ADDR_W  lane 0 uses [ADDR_W-1:0], lane 1 uses the upper field.
- req_wdata  in  2*DATA_W  per-lane write data.
- req_size  in  8  per-lane access size in bits: [3:0] for lane 0, [7:4] for lane 1.
- rdata  out  2*DATA_W  per-lane read data. Nonzero only during that lane's `data_rdy` cycle of a read.
- data_rdy  out  2  per-lane one-cycle completion pulse.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  sticky protocol error. Present only with the configuration macro (see Configuration).

## Operation
- FSM states: IDLE, ACCESS, GAP.
- IDLE:
  - A lane is pending if its oe or we is 1.
  - If neither lane is pending, stay in IDLE.
  - If exactly one lane is pending, grant it.
  - If both are pending, grant the lane selected by the round-robin pointer `rr`.
  - On grant, register lane, op (read if oe is set, else write), addr, wdata and size, and go to ACCESS.
  - Load the counter with READ_DELAY-1 for a read or WRITE_DELAY-1 for a write.
  - After each grant, set `rr` to the other lane.
- Write commit:
  - Memory is written at the grant edge.
  - Write mask = (1<<size)-1, truncated to 8 bits; size >= 8 gives a full byte.
  - New byte = (wdata & mask) | (old & ~mask).
  - size = 0 leaves memory unchanged, but the write still completes.
- Read:
  - The memory is read at the grant edge into a pipeline register.
  - The read is not re-sampled, so a write to the same address during ACCESS cannot occur.
- ACCESS:
  - Decrement the counter each cycle.
  - When the counter is 0, assert `data_rdy[lane]` for that cycle. For a read, also drive `rdata[lane]` with the registered byte.
  - Then go to GAP.
- GAP:
  - Lasts one cycle with no grant, which lets the master drop the completed request.
  - Then return to IDLE.
  - A request still held in GAP is treated as a new access in IDLE.
- If both oe and we are set on one lane, the access is treated as a read.
- The memory array is not reset. Its contents survive reset.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - FSM goes to IDLE, `rr`=0, counter=0.
  - `data_rdy`=0, `rdata`=0, `busy`=0, `err`=0.
- Reset during ACCESS aborts the access with no `data_rdy`. A write already committed at its grant edge stays committed.
- Latency, with grant at edge t0:
  - Read `data_rdy` is high in cycle t0+READ_DELAY, i.e. after READ_DELAY rising edges.
  - Write `data_rdy` is high in cycle t0+WRITE_DELAY.
- Throughput: one access every DELAY+2 cycles (grant, DELAY, GAP).
- Simultaneous requests in IDLE: the `rr` lane wins. The loser keeps its request asserted and is granted at the next IDLE.
- `busy` is registered and equals (state != IDLE).

## Configuration
- `MEMARB_PROTOCOL_CHECK_EN` defined:
  - The `err` port exists.
  - `err` is set at any rising edge where oe and we are both 1 on the same lane, or where a lane drops its request before its `data_rdy`.
  - `err` is cleared only by reset.
  - Arbitration behaviour is unchanged.
- Not defined: the `err` port and its checking logic are absent. The oe+we case is still served as a read.

## Test plan
- Single read, READ_DELAY=2: preload mem[0x05]=0xA7; hold lane 0 oe with addr 0x05 from cycle 10 -> `data_rdy[0]` high in cycle 12 only, rdata[7:0]=0xA7, rdata[15:8]=0.
- Masked write: mem[0x10]=0xFF; lane 1 we, wdata=0x00, size=4 -> `data_rdy[1]` 1 cycle after grant; a following read of 0x10 returns 0xF0.
- Contention: both lanes issue reads in the same cycle after reset (`rr`=0) -> lane 0 is served first, lane 1 gets `data_rdy` exactly READ_DELAY+2 cycles later; on the next contention lane 1 wins.
- Back-to-back writes from lane 0 (0x01<-0x11, then 0x02<-0x22), each held until `data_rdy` -> 3-cycle spacing with WRITE_DELAY=1; reads return 0x11 and 0x22.
- Reset mid-ACCESS of a read -> `data_rdy` never pulses, `busy`=0 immediately, memory contents unchanged.
- With `MEMARB_PROTOCOL_CHECK_EN`: lane 0 oe=we=1 -> served as a read and `err`=1 persists until reset. Without the macro, the same stimulus is served as a read and there is no `err` port.

Source files
------------

// File: rtl/bambu_mem_port_arbiter.sv
// Round-robin two-lane arbiter in front of a single-port byte scratch memory, with programmable read/write latency.
// Optional MEMARB_PROTOCOL_CHECK_EN adds the sticky err output for master protocol violations.
module bambu_mem_port_arbiter #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req_oe,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [7:0]            req_size,
    output logic [2*DATA_W-1:0]   rdata,
    output logic [1:0]            data_rdy,
    output logic                  busy
`ifdef MEMARB_PROTOCOL_CHECK_EN
    ,
    output logic                  err
`endif
);

    // state  | meaning
    // IDLE   | waiting for a request; grants, commits writes, samples reads
    // ACCESS | latency countdown; data_rdy pulses when the counter reaches 0
    // GAP    | one dead cycle so the master can drop the completed request
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam int MAX_D = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int CNT_W = (MAX_D < 2) ? 1 : $clog2(MAX_D);

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic                rr;
    logic                lane_q;
    logic                rd_op_q;
    logic [DATA_W-1:0]   rd_q;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic [1:0]          pend;
    logic                grant;
    logic                gnt_lane;
    logic                g_oe;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;
    logic [3:0]          g_size;
    logic [DATA_W-1:0]   g_mask;
    logic                rdy_now;

    assign pend = req_oe | req_we;

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        gnt_lane = 1'b0;
        case (state)
            IDLE: begin
                if (pend != 2'b00) begin
                    grant    = 1'b1;
                    gnt_lane = (pend == 2'b11) ? rr : pend[1];
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0)
                    state_nx = GAP;
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A lane with both oe and we set is served as a read.
    assign g_oe    = req_oe[gnt_lane];
    assign g_addr  = gnt_lane ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign g_wdata = gnt_lane ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    assign g_size  = gnt_lane ? req_size[7:4] : req_size[3:0];
    assign g_mask  = (g_size >= 4'(DATA_W)) ? {DATA_W{1'b1}}
                                             : DATA_W'((32'd1 << g_size) - 32'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rr      <= 1'b0;
            lane_q  <= 1'b0;
            rd_op_q <= 1'b0;
            rd_q    <= '0;
            busy    <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            if (grant) begin
                lane_q  <= gnt_lane;
                rd_op_q <= g_oe;
                rr      <= ~gnt_lane;
                rd_q    <= mem[g_addr];
                cnt     <= g_oe ? CNT_W'(READ_DELAY - 1) : CNT_W'(WRITE_DELAY - 1);
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Memory is never reset; writes commit at the grant edge.
    always_ff @(posedge clock) begin
        if (reset && grant && !g_oe)
            mem[g_addr] <= (g_wdata & g_mask) | (mem[g_addr] & ~g_mask);
    end

    assign rdy_now  = (state == ACCESS) && (cnt == '0);
    assign data_rdy = rdy_now ? (lane_q ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        rdata = '0;
        if (rdy_now && rd_op_q) begin
            if (lane_q)
                rdata[2*DATA_W-1:DATA_W] = rd_q;
            else
                rdata[DATA_W-1:0] = rd_q;
        end
    end

`ifdef MEMARB_PROTOCOL_CHECK_EN
    // Dropping is only a violation while the countdown is still running.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if ((req_oe & req_we) != 2'b00 ||
                 (state == ACCESS && cnt != '0 && !pend[lane_q]))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_bambu_mem_port_arbiter.sv
// Self-checking bench for bambu_mem_port_arbiter: vector table, hand sequences, random ops vs memory model.
module tb_bambu_mem_port_arbiter;

    localparam int RD = 2;
    localparam int WD = 1;

    logic        clock;
    logic        reset;
    logic [1:0]  req_oe;
    logic [1:0]  req_we;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic [7:0]  req_size;
    logic [15:0] rdata;
    logic [1:0]  data_rdy;
    logic        busy;
`ifdef MEMARB_PROTOCOL_CHECK_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] mdl [128];

    bambu_mem_port_arbiter #(
        .ADDR_W(7), .DATA_W(8), .READ_DELAY(RD), .WRITE_DELAY(WD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_oe(req_oe),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_size(req_size),
        .rdata(rdata),
        .data_rdy(data_rdy),
        .busy(busy)
`ifdef MEMARB_PROTOCOL_CHECK_EN
        ,
        .err(err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_req();
        req_oe = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_size = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 20) chk("idle_timeout", busy, 0);
    endtask

    // Single access from one lane; lat counts rising edges from the grant edge (1) to data_rdy.
    task automatic access(input int lane, input bit oe, input bit we, input logic [6:0] addr,
                          input logic [7:0] wd, input logic [3:0] sz,
                          output logic [7:0] rd, output int lat);
        wait_idle();
        clear_req();
        req_oe[lane] = oe;
        req_we[lane] = we;
        req_addr[lane*7 +: 7]  = addr;
        req_wdata[lane*8 +: 8] = wd;
        req_size[lane*4 +: 4]  = sz;
        lat = -1;
        rd  = '0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clock); #1;
            if (data_rdy[lane]) begin
                lat = n;
                rd  = rdata[lane*8 +: 8];
                chk("other_lane_rdy", data_rdy[1-lane], 0);
                chk("other_lane_rdata", rdata[(1-lane)*8 +: 8], 0);
                break;
            end else if (rdata !== 16'h0 || data_rdy !== 2'b00) begin
                chk("quiet_outputs", {rdata, 14'h0, data_rdy}, 0);
            end
        end
        clear_req();
    endtask

    task automatic contend(input int first, input logic [6:0] a0, input logic [6:0] a1,
                           input logic [7:0] e0, input logic [7:0] e1);
        int t[2];
        logic [7:0] d[2];
        wait_idle();
        clear_req();
        req_oe = 2'b11;
        req_addr = {a1, a0};
        req_size = 8'h88;
        t = '{-1, -1};
        d = '{8'h0, 8'h0};
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock); #1;
            for (int l = 0; l < 2; l++) begin
                if (data_rdy[l] && t[l] < 0) begin
                    t[l] = n;
                    d[l] = rdata[l*8 +: 8];
                    req_oe[l] = 1'b0;
                end
            end
            if (t[0] >= 0 && t[1] >= 0) break;
        end
        clear_req();
        chk("contend_winner_lat", t[first], RD);
        chk("contend_loser_lat", t[1-first], 2*RD + 2);
        chk("contend_rdata0", d[0], e0);
        chk("contend_rdata1", d[1], e1);
    endtask

    typedef struct {
        int         lane;
        bit         oe;
        bit         we;
        logic [6:0] addr;
        logic [7:0] wd;
        logic [3:0] sz;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [7:0] rd;
        int lat, t1, t2;
        bit seen;

        tbl[0]  = '{0, 1'b0, 1'b1, 7'h05, 8'hA7, 4'd8,  8'h00};
        tbl[1]  = '{0, 1'b1, 1'b0, 7'h05, 8'h00, 4'd8,  8'hA7};
        tbl[2]  = '{1, 1'b0, 1'b1, 7'h10, 8'hFF, 4'd8,  8'h00};
        tbl[3]  = '{1, 1'b0, 1'b1, 7'h10, 8'h00, 4'd4,  8'h00};
        tbl[4]  = '{0, 1'b1, 1'b0, 7'h10, 8'h00, 4'd0,  8'hF0};
        tbl[5]  = '{0, 1'b0, 1'b1, 7'h01, 8'h33, 4'd8,  8'h00};
        tbl[6]  = '{0, 1'b0, 1'b1, 7'h02, 8'h44, 4'd15, 8'h00};
        tbl[7]  = '{1, 1'b1, 1'b0, 7'h01, 8'h00, 4'd8,  8'h33};
        tbl[8]  = '{1, 1'b1, 1'b0, 7'h02, 8'h00, 4'd8,  8'h44};
        tbl[9]  = '{1, 1'b0, 1'b1, 7'h02, 8'hFF, 4'd0,  8'h00};
        tbl[10] = '{0, 1'b1, 1'b0, 7'h02, 8'h00, 4'd8,  8'h44};
        tbl[11] = '{0, 1'b0, 1'b1, 7'h7F, 8'h5A, 4'd8,  8'h00};
        tbl[12] = '{1, 1'b1, 1'b1, 7'h7F, 8'h00, 4'd8,  8'h5A};
        tbl[13] = '{1, 1'b1, 1'b0, 7'h7F, 8'h00, 4'd8,  8'h5A};
        tbl[14] = '{0, 1'b0, 1'b1, 7'h11, 8'hFF, 4'd8,  8'h00};
        tbl[15] = '{1, 1'b0, 1'b1, 7'h11, 8'h00, 4'd1,  8'h00};
        tbl[16] = '{0, 1'b1, 1'b0, 7'h11, 8'h00, 4'd8,  8'hFE};

        clear_req();
        reset = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_rdy", data_rdy, 0);
        chk("reset_rdata", rdata, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
`ifdef MEMARB_PROTOCOL_CHECK_EN
        chk("reset_err", err, 0);
`endif

        for (int i = 0; i < 17; i++) begin
            access(tbl[i].lane, tbl[i].oe, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].sz, rd, lat);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].oe ? RD : WD);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        end

        // Back-to-back held writes on lane 0
        wait_idle();
        clear_req();
        req_we = 2'b01; req_addr[6:0] = 7'h01; req_wdata[7:0] = 8'h11; req_size = 8'h08;
        t1 = -1; t2 = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clock); #1;
            if (data_rdy[0]) begin
                if (t1 < 0) begin
                    t1 = n;
                    req_addr[6:0] = 7'h02; req_wdata[7:0] = 8'h22;
                end else begin
                    t2 = n;
                    break;
                end
            end
        end
        clear_req();
        chk("b2b_first_lat", t1, WD);
        chk("b2b_spacing", t2 - t1, WD + 2);
        access(1, 1'b1, 1'b0, 7'h01, 8'h00, 4'd8, rd, lat);
        chk("b2b_read1", rd, 8'h11);
        access(0, 1'b1, 1'b0, 7'h02, 8'h00, 4'd8, rd, lat);
        chk("b2b_read2", rd, 8'h22);

        // Contention right after reset: lane 0 first; then rr moves to lane 1
        apply_reset();
        contend(0, 7'h05, 7'h7F, 8'hA7, 8'h5A);
        apply_reset();
        access(0, 1'b1, 1'b0, 7'h01, 8'h00, 4'd8, rd, lat);
        chk("pre_contend_read", rd, 8'h11);
        contend(1, 7'h10, 7'h02, 8'hF0, 8'h22);

        // Reset during a read ACCESS
        access(0, 1'b0, 1'b1, 7'h20, 8'h3C, 4'd8, rd, lat);
        chk("abort_prewrite_lat", lat, WD);
        wait_idle();
        clear_req();
        req_oe = 2'b01; req_addr[6:0] = 7'h20;
        @(posedge clock); #1;
        chk("abort_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_busy_now", busy, 0);
        seen = data_rdy[0];
        clear_req();
        for (int n = 0; n < 4; n++) begin
            @(posedge clock); #1;
            if (data_rdy !== 2'b00) seen = 1'b1;
        end
        chk("abort_no_rdy", seen, 0);
        reset = 1'b1;
        access(0, 1'b1, 1'b0, 7'h20, 8'h00, 4'd8, rd, lat);
        chk("abort_mem_kept", rd, 8'h3C);

`ifdef MEMARB_PROTOCOL_CHECK_EN
        apply_reset();
        chk("err_clear", err, 0);
        access(0, 1'b1, 1'b1, 7'h20, 8'h00, 4'd8, rd, lat);
        chk("err_oewe_read", rd, 8'h3C);
        chk("err_set", err, 1);
        repeat (5) @(posedge clock);
        #1 chk("err_sticky", err, 1);
        apply_reset();
        chk("err_reset", err, 0);
`endif

        // Random phase against a byte-array model
        for (int a = 0; a < 128; a++) begin
            mdl[a] = 8'((a * 37 + 11) % 256);
            access(a % 2, 1'b0, 1'b1, 7'(a), mdl[a], 4'd8, rd, lat);
        end
        for (int i = 0; i < 120; i++) begin
            int lane, kind, a, sz;
            logic [7:0] wd, mask;
            lane = $urandom_range(0, 1);
            kind = $urandom_range(0, 2);
            a    = $urandom_range(0, 127);
            sz   = $urandom_range(0, 15);
            wd   = 8'($urandom);
            access(lane, kind != 1, kind != 0, 7'(a), wd, 4'(sz), rd, lat);
            if (kind == 1) begin
                mask = (sz >= 8) ? 8'hFF : 8'(2 ** sz - 1);
                mdl[a] = (wd & mask) | (mdl[a] & ~mask);
                chk($sformatf("rnd%0d_wlat", i), lat, WD);
                chk($sformatf("rnd%0d_wrdata", i), rd, 0);
            end else begin
                chk($sformatf("rnd%0d_rlat", i), lat, RD);
                chk($sformatf("rnd%0d_rdata", i), rd, mdl[a]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
